instruction_fetch_buffer: RTL and testbench
===========================================

INSTRUCTION_FETCH_BUFFER -- requirements
Module: instruction_fetch_buffer

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, 32, instruction word width; DEPTH, 64, program memory entries; ADDR_WIDTH, 6, log2(DEPTH).
REQ-002 SHALL have ports, in this order:
- clock_in  input  1  sole clock, rising edge.
- reset_n_in  input  1  asynchronous, active-low reset.
- load_valid_in  input  1  loader word valid.
- load_data_in  input  DATA_WIDTH  machine-code word from loader.
- load_ready_out  output  1  buffer accepts load word.
- load_done_in  input  1  end of program image.
- start_in  input  1  begin or restart execution at pc 0.
- instruction_out  output  DATA_WIDTH  instruction to cpu.
- instruction_pc_out  output  ADDR_WIDTH  address of instruction_out.
- instruction_valid_out  output  1  instruction_out valid.
- instruction_ready_in  input  1  cpu consumes instruction.
- redirect_valid_in  input  1  cpu branch or jump taken.
- redirect_pc_in  input  ADDR_WIDTH  branch target.
- state_out  output  2  IDLE=0, LOAD=1, RUN=2, DONE=3.
- program_length_out  output  ADDR_WIDTH+1  words loaded.

Function
REQ-003 SHALL contain a DEPTH x DATA_WIDTH program memory with synchronous read, one-cycle read latency.
REQ-004 SHALL contain a 2-entry output FIFO; instruction_out/instruction_pc_out are the FIFO head; instruction_valid_out = FIFO non-empty.
REQ-005 Output handshake: an entry is consumed on a rising edge where instruction_valid_out and instruction_ready_in are both 1; head held stable while valid and not ready.
REQ-006 IDLE -> LOAD when load_valid_in=1; word is written at address program_length and program_length increments in the same cycle.
REQ-007 LOAD: load_ready_out = 1 while program_length < DEPTH, else 0; a word offered while full is dropped without length change.
REQ-008 LOAD -> IDLE on load_done_in=1; load_valid_in and load_done_in together: word written, then IDLE.
REQ-009 Entering LOAD from IDLE clears program_length to 0 before the first write (first word lands at address 0).
REQ-010 IDLE or DONE -> RUN on start_in=1 with program_length > 0, fetch pc set to 0, FIFO cleared; with program_length = 0 -> DONE.
REQ-011 start_in ignored in LOAD and RUN; load_valid_in ignored outside IDLE and LOAD; load_ready_out = 0 outside IDLE and LOAD.
REQ-012 RUN: a memory read issues at fetch pc when (FIFO occupancy + in-flight reads) < 2 and fetch pc < program_length; fetch pc increments per issue; returned data enters FIFO one cycle later tagged with its pc.
REQ-013 Sustained throughput SHALL be one instruction per cycle with instruction_ready_in held at 1; first valid instruction 2 cycles after the start_in edge.
REQ-014 redirect_valid_in in RUN: any same-cycle handshake completes, then FIFO flushed, in-flight read discarded, fetch pc = redirect_pc_in; instruction_valid_out = 0 next cycle.
REQ-015 Redirect to pc >= program_length: flush as REQ-014, no further issue.
REQ-016 RUN -> DONE when fetch pc >= program_length, FIFO empty and no read in flight.
REQ-017 fetch pc compared at ADDR_WIDTH+1 bits; no wrap from DEPTH-1 to 0.
REQ-018 redirect_valid_in outside RUN ignored.

Reset
REQ-019 reset_n_in = 0 SHALL asynchronously force: state_out=IDLE, program_length_out=0, fetch pc=0, FIFO empty, in-flight cleared, instruction_valid_out=0, instruction_out=0, instruction_pc_out=0, load_ready_out=0.
REQ-020 Program memory contents SHALL NOT be reset.
REQ-021 Reset mid-LOAD or mid-RUN SHALL abandon the operation; first cycle after deassertion is IDLE with load_ready_out=1.
REQ-022 Reset deassertion SHALL be taken on a clock_in edge; no output changes before that edge.

Verification
REQ-023 Load 0x11111111, 0x22222222, 0x33333333 with load_done_in on third, pulse start_in, ready=1 -> valid from cycle 2, words in order, pc 0,1,2, then state_out=DONE.
REQ-024 Same program, ready=0 for 5 cycles -> instruction_out holds 0x11111111, pc 0; no more than 2 reads issued.
REQ-025 10-word program, redirect to pc 7 while head pc=2 -> next valid is word 7, pc 7; words 3-6 never presented.
REQ-026 Load 65 words -> load_ready_out=0 after 64th, program_length_out=64, 65th dropped.
REQ-027 start_in with program_length=0 -> DONE, instruction_valid_out never 1; reset asserted mid-RUN -> all outputs at REQ-019 values immediately.

Source files
------------

// File: rtl/instruction_fetch_buffer.sv
// Instruction fetch buffer: captures a program image into local memory, then
// streams it to the cpu through a 2-entry FIFO with branch redirect support.
//
// state | meaning
// IDLE  | waiting for a load word or start
// LOAD  | accepting program words into memory
// RUN   | fetching and presenting instructions
// DONE  | program exhausted; start re-runs from pc 0
module instruction_fetch_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 64,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clock_in,
    input  logic                  reset_n_in,
    input  logic                  load_valid_in,
    input  logic [DATA_WIDTH-1:0] load_data_in,
    output logic                  load_ready_out,
    input  logic                  load_done_in,
    input  logic                  start_in,
    output logic [DATA_WIDTH-1:0] instruction_out,
    output logic [ADDR_WIDTH-1:0] instruction_pc_out,
    output logic                  instruction_valid_out,
    input  logic                  instruction_ready_in,
    input  logic                  redirect_valid_in,
    input  logic [ADDR_WIDTH-1:0] redirect_pc_in,
    output logic [1:0]            state_out,
    output logic [ADDR_WIDTH:0]   program_length_out
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

    state_t                state, state_nxt;
    logic [ADDR_WIDTH:0]   prog_len;
    logic [ADDR_WIDTH:0]   fetch_pc;
    logic                  out_en;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data;
    logic [ADDR_WIDTH-1:0] rd_pc;
    logic                  rd_pending;
    logic [DATA_WIDTH-1:0] q_data [2];
    logic [ADDR_WIDTH-1:0] q_pc [2];
    logic [1:0]            q_cnt;

    logic                  load_fire, start_go, run_redirect, flush;
    logic                  pop, push, issue, len_zero, fetch_done;
    logic [2:0]            occ;
    logic [ADDR_WIDTH-1:0] wr_addr;

    assign len_zero     = (prog_len == '0);
    assign fetch_done   = (fetch_pc >= prog_len);
    assign load_fire    = load_valid_in && load_ready_out;
    assign start_go     = start_in && !len_zero &&
                          ((state == S_IDLE && !load_fire) || state == S_DONE);
    assign run_redirect = (state == S_RUN) && redirect_valid_in;
    assign flush        = start_go || run_redirect;
    assign pop          = instruction_valid_out && instruction_ready_in;
    assign push         = rd_pending && !flush;
    // Occupancy after this cycle's pop, so a consumed slot can refill at once.
    assign occ          = {1'b0, q_cnt} + {2'b00, rd_pending} - {2'b00, pop};
    assign issue        = (state == S_RUN) && !redirect_valid_in && !fetch_done && (occ < 3'd2);
    assign wr_addr      = (state == S_IDLE) ? '0 : prog_len[ADDR_WIDTH-1:0];

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) state <= S_IDLE;
        else             state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (load_fire)     state_nxt = load_done_in ? S_IDLE : S_LOAD;
                else if (start_in) state_nxt = len_zero ? S_DONE : S_RUN;
            end
            S_LOAD: if (load_done_in) state_nxt = S_IDLE;
            S_RUN: begin
                if (!redirect_valid_in && fetch_done && q_cnt == 2'd0 && !rd_pending)
                    state_nxt = S_DONE;
            end
            S_DONE: if (start_in) state_nxt = len_zero ? S_DONE : S_RUN;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        load_ready_out        = out_en && (state == S_IDLE || (state == S_LOAD && prog_len < DEPTH_W));
        instruction_valid_out = (q_cnt != 2'd0);
    end

    assign state_out          = state;
    assign program_length_out = prog_len;
    assign instruction_out    = q_data[0];
    assign instruction_pc_out = q_pc[0];

    // Program memory is deliberately left out of reset.
    always_ff @(posedge clock_in) begin
        if (load_fire) mem[wr_addr] <= load_data_in;
        if (issue)     rd_data <= mem[fetch_pc[ADDR_WIDTH-1:0]];
    end

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            out_en     <= 1'b0;
            prog_len   <= '0;
            fetch_pc   <= '0;
            rd_pending <= 1'b0;
            rd_pc      <= '0;
            q_cnt      <= '0;
            q_data[0]  <= '0;
            q_data[1]  <= '0;
            q_pc[0]    <= '0;
            q_pc[1]    <= '0;
        end else begin
            out_en     <= 1'b1;
            rd_pending <= issue;
            if (issue) rd_pc <= fetch_pc[ADDR_WIDTH-1:0];
            if (load_fire) prog_len <= (state == S_IDLE) ? (ADDR_WIDTH+1)'(1) : prog_len + 1'b1;

            if (start_go)          fetch_pc <= '0;
            else if (run_redirect) fetch_pc <= {1'b0, redirect_pc_in};
            else if (issue)        fetch_pc <= fetch_pc + 1'b1;

            if (flush) begin
                q_cnt <= '0;
            end else begin
                case ({push, pop})
                    2'b10: begin
                        if (q_cnt == 2'd0) begin
                            q_data[0] <= rd_data;
                            q_pc[0]   <= rd_pc;
                        end else begin
                            q_data[1] <= rd_data;
                            q_pc[1]   <= rd_pc;
                        end
                        q_cnt <= q_cnt + 2'd1;
                    end
                    2'b01: begin
                        q_data[0] <= q_data[1];
                        q_pc[0]   <= q_pc[1];
                        q_cnt     <= q_cnt - 2'd1;
                    end
                    2'b11: begin
                        if (q_cnt == 2'd1) begin
                            q_data[0] <= rd_data;
                            q_pc[0]   <= rd_pc;
                        end else begin
                            q_data[0] <= q_data[1];
                            q_pc[0]   <= q_pc[1];
                            q_data[1] <= rd_data;
                            q_pc[1]   <= rd_pc;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_instruction_fetch_buffer.sv
// Bench for instruction_fetch_buffer: directed load/run/redirect/reset scenarios
// plus a program-order stream model checked on every falling edge.
module tb_instruction_fetch_buffer;
    localparam int DW = 32, DEPTH = 64, AW = 6;

    logic          clock_in = 1'b0;
    logic          reset_n_in = 1'b0;
    logic          load_valid_in = 1'b0;
    logic [DW-1:0] load_data_in = '0;
    logic          load_ready_out;
    logic          load_done_in = 1'b0;
    logic          start_in = 1'b0;
    logic [DW-1:0] instruction_out;
    logic [AW-1:0] instruction_pc_out;
    logic          instruction_valid_out;
    logic          instruction_ready_in = 1'b0;
    logic          redirect_valid_in = 1'b0;
    logic [AW-1:0] redirect_pc_in = '0;
    logic [1:0]    state_out;
    logic [AW:0]   program_length_out;

    instruction_fetch_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clock_in(clock_in), .reset_n_in(reset_n_in),
        .load_valid_in(load_valid_in), .load_data_in(load_data_in),
        .load_ready_out(load_ready_out), .load_done_in(load_done_in),
        .start_in(start_in), .instruction_out(instruction_out),
        .instruction_pc_out(instruction_pc_out), .instruction_valid_out(instruction_valid_out),
        .instruction_ready_in(instruction_ready_in), .redirect_valid_in(redirect_valid_in),
        .redirect_pc_in(redirect_pc_in), .state_out(state_out),
        .program_length_out(program_length_out)
    );

    always #5 clock_in = ~clock_in;

    int checks = 0, errors = 0;
    logic [DW-1:0] prog_m [DEPTH];
    int len_m = 0;
    int exp_pc = 0;
    int n_hs = 0;
    bit post_redir = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Stream model: the cpu must see the program in pc order, restarting at 0
    // on start and jumping to the target on a redirect.
    always @(negedge clock_in) begin
        if (!reset_n_in) begin
            exp_pc = 0;
            post_redir = 1'b0;
        end else begin
            if (post_redir) chk("valid_after_redirect", 64'(instruction_valid_out), 64'd0);
            post_redir = 1'b0;
            if (instruction_valid_out) begin
                chk("stream_pc", 64'(instruction_pc_out), 64'(exp_pc));
                if (exp_pc < len_m) chk("stream_data", 64'(instruction_out), 64'(prog_m[exp_pc]));
                else begin
                    checks++; errors++;
                    $display("FAIL stream_beyond_len: got pc %0d expected below %0d", instruction_pc_out, len_m);
                end
            end
            if (start_in) exp_pc = 0;
            else if (redirect_valid_in) begin
                if (instruction_valid_out && instruction_ready_in) n_hs++;
                exp_pc = int'(redirect_pc_in);
                post_redir = 1'b1;
            end else if (instruction_valid_out && instruction_ready_in) begin
                exp_pc++;
                n_hs++;
            end
        end
    end

    task automatic tick();
        @(posedge clock_in); #1;
    endtask

    task automatic do_reset();
        reset_n_in = 1'b0; load_valid_in = 1'b0; load_done_in = 1'b0;
        start_in = 1'b0; redirect_valid_in = 1'b0; instruction_ready_in = 1'b0;
        #1;
        chk("rst_state", 64'(state_out), 64'd0);
        chk("rst_len", 64'(program_length_out), 64'd0);
        chk("rst_valid", 64'(instruction_valid_out), 64'd0);
        chk("rst_instr", 64'(instruction_out), 64'd0);
        chk("rst_pc", 64'(instruction_pc_out), 64'd0);
        chk("rst_ready", 64'(load_ready_out), 64'd0);
        len_m = 0;
        tick(); tick();
        reset_n_in = 1'b1;
        #1 chk("rst_ready_pre_edge", 64'(load_ready_out), 64'd0);
        tick();
        chk("rst_ready_post_edge", 64'(load_ready_out), 64'd1);
        chk("rst_idle_post_edge", 64'(state_out), 64'd0);
    endtask

    task automatic load_words(input int n, input logic [31:0] base, input logic [31:0] step, input bit done_last);
        for (int i = 0; i < n; i++) begin
            load_valid_in = 1'b1;
            load_data_in  = base + step * 32'(i);
            load_done_in  = done_last && (i == n - 1);
            if (i < DEPTH) prog_m[i] = base + step * 32'(i);
            tick();
        end
        load_valid_in = 1'b0;
        load_done_in  = 1'b0;
        if (!done_last) begin
            load_done_in = 1'b1; tick(); load_done_in = 1'b0;
        end
        len_m = (n < DEPTH) ? n : DEPTH;
    endtask

    task automatic wait_state(input logic [1:0] s, input int budget, input string name);
        for (int i = 0; i < budget && state_out != s; i++) tick();
        chk(name, 64'(state_out), 64'(s));
    endtask

    task automatic pulse_start();
        start_in = 1'b1; tick(); start_in = 1'b0;
    endtask

    int hs0;

    initial begin
        do_reset();

        // Start with an empty program goes straight to DONE, nothing presented.
        pulse_start();
        chk("t27_empty_done", 64'(state_out), 64'd3);
        for (int i = 0; i < 4; i++) begin
            chk("t27_empty_no_valid", 64'(instruction_valid_out), 64'd0);
            tick();
        end

        // Three-word program streamed with ready held high.
        do_reset();
        load_words(3, 32'h11111111, 32'h11111111, 1'b1);
        chk("t23_idle", 64'(state_out), 64'd0);
        chk("t23_len", 64'(program_length_out), 64'd3);
        instruction_ready_in = 1'b1;
        hs0 = n_hs;
        pulse_start();
        chk("t23_run", 64'(state_out), 64'd2);
        chk("t23_valid_c0", 64'(instruction_valid_out), 64'd0);
        tick();
        chk("t23_valid_c1", 64'(instruction_valid_out), 64'd0);
        tick();
        chk("t23_valid_c2", 64'(instruction_valid_out), 64'd1);
        chk("t23_w0", 64'(instruction_out), 64'h11111111);
        chk("t23_pc0", 64'(instruction_pc_out), 64'd0);
        tick();
        chk("t23_w1", 64'(instruction_out), 64'h22222222);
        chk("t23_pc1", 64'(instruction_pc_out), 64'd1);
        tick();
        chk("t23_w2", 64'(instruction_out), 64'h33333333);
        chk("t23_pc2", 64'(instruction_pc_out), 64'd2);
        wait_state(2'd3, 10, "t23_done");
        chk("t23_consumed", 64'(n_hs - hs0), 64'd3);

        // Rerun from DONE with the cpu stalled; head must hold.
        instruction_ready_in = 1'b0;
        hs0 = n_hs;
        pulse_start();
        tick(); tick();
        for (int i = 0; i < 5; i++) begin
            chk("t24_hold_valid", 64'(instruction_valid_out), 64'd1);
            chk("t24_hold_w0", 64'(instruction_out), 64'h11111111);
            chk("t24_hold_pc0", 64'(instruction_pc_out), 64'd0);
            tick();
        end
        instruction_ready_in = 1'b1;
        wait_state(2'd3, 20, "t24_done");
        chk("t24_consumed", 64'(n_hs - hs0), 64'd3);

        // Redirect to pc 7 while pc 2 is at the head.
        do_reset();
        load_words(10, 32'hC0DE0000, 32'h01010101, 1'b0);
        chk("t25_len", 64'(program_length_out), 64'd10);
        instruction_ready_in = 1'b1;
        hs0 = n_hs;
        pulse_start();
        for (int i = 0; i < 20 && !(instruction_valid_out && instruction_pc_out == 6'd2); i++) tick();
        chk("t25_head_pc2", 64'(instruction_pc_out), 64'd2);
        redirect_valid_in = 1'b1; redirect_pc_in = 6'd7;
        tick();
        redirect_valid_in = 1'b0;
        for (int i = 0; i < 10 && !instruction_valid_out; i++) tick();
        chk("t25_target_word", 64'(instruction_out), 64'hC7E50707);
        chk("t25_target_pc", 64'(instruction_pc_out), 64'd7);
        wait_state(2'd3, 20, "t25_done");
        chk("t25_consumed", 64'(n_hs - hs0), 64'd6);

        // Fill memory completely; the 65th word is dropped.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            load_valid_in = 1'b1;
            load_data_in  = 32'h50000000 + 32'(3 * i);
            prog_m[i]     = 32'h50000000 + 32'(3 * i);
            tick();
        end
        chk("t26_ready_full", 64'(load_ready_out), 64'd0);
        chk("t26_len_full", 64'(program_length_out), 64'd64);
        chk("t26_state_load", 64'(state_out), 64'd1);
        chk("t26_model_last", 64'(prog_m[63]), 64'h500000BD);
        load_data_in = 32'hFFFFFFFF; load_done_in = 1'b1;
        tick();
        load_valid_in = 1'b0; load_done_in = 1'b0;
        chk("t26_len_after_drop", 64'(program_length_out), 64'd64);
        chk("t26_idle", 64'(state_out), 64'd0);
        len_m = DEPTH;
        instruction_ready_in = 1'b1;
        hs0 = n_hs;
        pulse_start();
        wait_state(2'd3, 120, "t26_done");
        chk("t26_consumed", 64'(n_hs - hs0), 64'd64);

        // Reset asserted in the middle of RUN.
        do_reset();
        load_words(3, 32'h11111111, 32'h11111111, 1'b1);
        instruction_ready_in = 1'b0;
        pulse_start();
        tick(); tick();
        chk("t27_run_valid", 64'(instruction_valid_out), 64'd1);
        #2 reset_n_in = 1'b0;
        #1;
        chk("t27_rst_state", 64'(state_out), 64'd0);
        chk("t27_rst_len", 64'(program_length_out), 64'd0);
        chk("t27_rst_valid", 64'(instruction_valid_out), 64'd0);
        chk("t27_rst_instr", 64'(instruction_out), 64'd0);
        chk("t27_rst_pc", 64'(instruction_pc_out), 64'd0);
        chk("t27_rst_ready", 64'(load_ready_out), 64'd0);
        len_m = 0;
        tick();
        reset_n_in = 1'b1;
        tick();
        chk("t27_after_idle", 64'(state_out), 64'd0);
        chk("t27_after_ready", 64'(load_ready_out), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
